// File: rtl/mem_access_unit.sv
// Memory access unit: turns control-FSM strobes into one req/ack bus transaction,
// owns IR and MDR, and stalls the control FSM until the access completes.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ir_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] ir,
  output logic [5:0]        opcode,
  output logic [DATA_W-1:0] mdr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic              cmd_we_q, cmd_we_d;
  logic              cmd_ir_q, cmd_ir_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              request;
  logic              cnt_expired;

  assign request     = mem_read | mem_write | ir_write;
  // The current WAIT cycle is the TIMEOUT-th one when the counter is about to reach TIMEOUT.
  assign cnt_expired = (cnt_q + 8'd1) == TIMEOUT_CNT;

  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_ir_d    = cmd_ir_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (request) begin
          cmd_we_d    = mem_write;
          cmd_ir_d    = ir_write & ~mem_write;
          bus_addr_d  = addr;
          bus_wdata_d = wdata;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          cnt_d       = 8'd0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_ack) begin
          if (!cmd_we_q) begin
            mdr_d = bus_rdata;
            if (cmd_ir_q) ir_d = bus_rdata;
          end
          cnt_d     = 8'd0;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          state_d   = ST_DONE;
        end else if (cnt_expired) begin
          // Aborted reads return a NOP so the control FSM decodes something harmless.
          timeout_d = 1'b1;
          if (!cmd_we_q) begin
            mdr_d = '0;
            if (cmd_ir_q) ir_d = '0;
          end
          cnt_d     = 8'd0;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
        bus_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_we_q    <= 1'b0;
      cmd_ir_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      ir_q        <= '0;
      mdr_q       <= '0;
      timeout_q   <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_ir_q    <= cmd_ir_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign stall       = ((state_q == ST_IDLE) & request) | (state_q == ST_WAIT);
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign ir          = ir_q;
  assign mdr         = mdr_q;
  assign opcode      = ir_q[DATA_W-1 -: 6];
  assign bus_timeout = timeout_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the multicycle control FSM and directly upstream of the datapath registers.
- Converts the control strobes mem_read, mem_write and ir_write into single transactions on a req/ack memory bus with variable latency.
- Owns the instruction register (IR) and the memory data register (MDR).
- Drives a stall that holds the control FSM and PC in their current state until the access completes.

Parameters:
DATA_W, 32, width of the data bus, IR and MDR
ADDR_W, 16, width of the memory address
TIMEOUT, 15, number of WAIT cycles without bus_ack before the access is aborted (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mem_read  in  1  read request from the control FSM
mem_write  in  1  write request from the control FSM
ir_write  in  1  read whose result is also loaded into IR
addr  in  ADDR_W  access address from the datapath
wdata  in  DATA_W  store data from the datapath
stall  out  1  holds the control FSM and PC when high
ir  out  DATA_W  instruction register
opcode  out  6  equals ir[DATA_W-1:DATA_W-6]; feeds control Op
mdr  out  DATA_W  memory data register
bus_req  out  1  bus request
bus_we  out  1  bus write enable
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_ack  in  1  access complete; bus_rdata is valid in the same cycle
bus_rdata  in  DATA_W  read data
bus_timeout  out  1  sticky flag: an access was aborted

Behaviour:
- Reset (reset=1 at a clk edge) forces:
  - state IDLE
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0
  - ir=0, mdr=0, bus_timeout=0
  - the timeout counter to 0
- Reset applied mid-access abandons the transaction: bus_req is low from the following cycle and no register is loaded.
- States: IDLE, WAIT, DONE.
- IDLE:
  - A request is present when (mem_read | mem_write | ir_write).
  - On a request, capture into registers:
    - cmd_we = mem_write
    - cmd_ir = ir_write & ~mem_write
    - bus_addr = addr
    - bus_wdata = wdata
  - Then go to WAIT.
  - Write has priority: when mem_write and ir_write are both high, a write is performed and IR is not updated.
- WAIT:
  - bus_req=1 and bus_we=cmd_we.
  - bus_addr and bus_wdata are held stable for the whole state.
  - The counter increments every cycle.
  - When bus_ack=1:
    - on a read, mdr <= bus_rdata; if cmd_ir, also ir <= bus_rdata
    - on a write, mdr and ir are unchanged
    - counter cleared; go to DONE
  - When the counter reaches TIMEOUT with no ack:
    - bus_timeout <= 1
    - a read loads 0 (NOP) into mdr, and into ir if cmd_ir
    - go to DONE
  - An ack in the timeout cycle takes priority: normal completion, no flag.
- DONE:
  - bus_req=0 and stall=0; this is the cycle in which the control FSM advances.
  - Unconditionally return to IDLE. Inputs in DONE are ignored.
  - A request still present in the next IDLE cycle starts a new access.
- stall is combinational: stall = (state==IDLE & request) | (state==WAIT).
- Latency: with a request at cycle 0 and ack at cycle 1, mdr/ir are valid and stall is low at cycle 2. The minimum stall is 2 cycles, and each extra wait cycle adds 1.
- bus_ack outside WAIT is ignored and has no effect.
- bus_req is registered and glitch-free. It is never high in two consecutive accesses without an intervening DONE and IDLE cycle.
- opcode is combinational from ir. After reset it is 0, which decodes as noop.
- bus_timeout is cleared only by reset.

Test Plan:
- Instruction fetch: ir_write=1, mem_read=1, addr=0x0004; bus acks at the first WAIT cycle with bus_rdata=0x4400_1234 -> stall high for exactly 2 cycles; then ir=0x4400_1234, opcode=6'b010001, mdr=0x4400_1234; bus_req high for 1 cycle.
- Store with wait states: mem_write=1, addr=0x0100, wdata=0xDEAD_BEEF; ack after 3 WAIT cycles -> bus_we=1 and bus_addr/bus_wdata stable for all 3 cycles; stall high for 4 cycles; mdr and ir unchanged.
- Write/ir_write collision: mem_write=1 and ir_write=1 together -> bus_we=1 and ir retains its prior value.
- Timeout: mem_read=1, no ack, TIMEOUT=15 -> DONE after 15 WAIT cycles; bus_timeout=1 and stays set; mdr=0; stall drops in the DONE cycle. Ack arriving on cycle 15 -> normal completion with bus_timeout=0.
- Reset mid-WAIT: assert reset during cycle 2 of WAIT -> next cycle bus_req=0, state IDLE, ir=0, mdr=0; a later ack is ignored and no register changes.
- Back-to-back reads: mem_read held high, ack always immediate -> repeating 3-cycle pattern (IDLE/req, WAIT, DONE); stall pattern 1,1,0; spurious ack in DONE ignored.
